// File: rtl/rooth_inst_loader_pkg.sv
// Shared constants for the rooth instruction boot loader: sync marker,
// loader FSM encodings and the core word width.
package rooth_inst_loader_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

  localparam logic [2:0] LDR_IDLE = 3'd0;
  localparam logic [2:0] LDR_LEN0 = 3'd1;
  localparam logic [2:0] LDR_LEN1 = 3'd2;
  localparam logic [2:0] LDR_DATA = 3'd3;
  localparam logic [2:0] LDR_CSUM = 3'd4;
  localparam logic [2:0] LDR_DONE = 3'd5;
  localparam logic [2:0] LDR_ERR  = 3'd6;

endpackage

// File: rtl/rooth_byte_packer.sv
// Assembles payload bytes into little-endian words and keeps the 8-bit
// running payload sum used for the frame checksum.
module rooth_byte_packer
  import rooth_inst_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 last_lane,
  output logic                 word_valid,
  output logic [CPU_WIDTH-1:0] word,
  output logic [7:0]           sum
);

  logic [1:0]           lane;
  logic [CPU_WIDTH-1:0] pack;

  assign last_lane = (lane == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane       <= '0;
      pack       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      sum        <= '0;
    end else begin
      // NOTE: word_valid defaults low each cycle so it can only ever be a single-cycle pulse.
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
        pack <= '0;
        sum  <= '0;
      end else if (byte_valid) begin
        pack[{lane, 3'b000} +: 8] <= byte_data;
        sum  <= sum + byte_data;
        lane <= lane + 2'd1;
        if (last_lane) begin
          word_valid <= 1'b1;
          word       <= {byte_data, pack[23:0]};
        end
      end
    end
  end

endmodule

// File: rtl/rooth_inst_loader.sv
// Framed byte-stream boot loader: writes a checksummed image into instruction
// memory and releases the rooth core from reset once the image verifies.
module rooth_inst_loader
  import rooth_inst_loader_pkg::*;
#(
  parameter int         IM_AW     = 12,
  parameter logic [7:0] SYNC_BYTE = LDR_SYNC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 im_we,
  output logic [IM_AW-1:0]     im_addr,
  output logic [CPU_WIDTH-1:0] im_wdata,
  output logic                 core_rst_n,
  output logic                 load_done,
  output logic                 load_err
);

  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [15:0]      len;
  logic [IM_AW:0]   word_cnt;
  logic [IM_AW:0]   word_next;
  logic [IM_AW-1:0] addr_q;
  logic [15:0]      len_in;
  logic             len_too_big;
  logic             last_word;
  logic [7:0]       csum_total;

  logic                 accept;
  logic                 pk_clear;
  logic                 pk_valid;
  logic                 pk_last;
  logic                 pk_word_valid;
  logic [CPU_WIDTH-1:0] pk_word;
  logic [7:0]           pk_sum;

  assign rx_ready = rst_n && (state != LDR_DONE);
  assign accept   = rx_valid && rx_ready;

  // The sum is also cleared for zero-length frames, which skip DATA entirely.
  assign pk_clear = accept && (state == LDR_LEN1);
  assign pk_valid = accept && (state == LDR_DATA);

  assign len_in      = {rx_data, len_lo};
  assign len_too_big = {1'b0, len_in} > (17'd1 << IM_AW);
  assign word_next   = word_cnt + 1'b1;
  assign last_word   = (17'(word_next) == {1'b0, len});
  assign csum_total  = pk_sum + rx_data;

  rooth_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .last_lane  (pk_last),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .sum        (pk_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LDR_IDLE;
      len_lo   <= '0;
      len      <= '0;
      word_cnt <= '0;
      addr_q   <= '0;
    end else if (accept) begin
      case (state)
        LDR_IDLE: if (rx_data == SYNC_BYTE) state <= LDR_LEN0;
        LDR_LEN0: begin
          len_lo <= rx_data;
          state  <= LDR_LEN1;
        end
        LDR_LEN1: begin
          len      <= len_in;
          word_cnt <= '0;
          if (len_in == 16'd0)  state <= LDR_CSUM;
          else if (len_too_big) state <= LDR_ERR;
          else                  state <= LDR_DATA;
        end
        LDR_DATA: begin
          // Payload bytes equal to the sync marker are data; no resync mid-frame.
          if (pk_last) begin
            addr_q   <= word_cnt[IM_AW-1:0];
            word_cnt <= word_next;
            if (last_word) state <= LDR_CSUM;
          end
        end
        LDR_CSUM: state <= (csum_total == 8'd0) ? LDR_DONE : LDR_ERR;
        LDR_ERR:  if (rx_data == SYNC_BYTE) state <= LDR_LEN0;
        default:  state <= state;
      endcase
    end
  end

  assign im_we      = pk_word_valid;
  assign im_addr    = addr_q;
  assign im_wdata   = pk_word;
  assign load_done  = rst_n && (state == LDR_DONE);
  assign core_rst_n = rst_n && (state == LDR_DONE);
  assign load_err   = rst_n && (state == LDR_ERR);

endmodule

// File: tb/tb_rooth_inst_loader.sv
// Directed bench for rooth_inst_loader: a table of complete frames plus
// hand-written sequences for timing, stalls, error recovery and reset.
module tb_rooth_inst_loader;

  localparam int IM_AW = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;
  logic             core_rst_n;
  logic             load_done;
  logic             load_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IM_AW-1:0] wa_q[$];
  logic [31:0]      wd_q[$];

  rooth_inst_loader #(.IM_AW(IM_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we) begin
      wa_q.push_back(im_addr);
      wd_q.push_back(im_wdata);
    end
  end

  typedef struct {
    string        name;
    int           n;
    logic [127:0] stream;
    int           exp_nw;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t vecs[5];

  localparam logic [95:0] GOOD_FRAME = 96'hA502_0013_0000_0093_0010_004A;
  localparam logic [95:0] BAD_FRAME  = 96'hA502_0013_0000_0093_0010_004B;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [127:0] s, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      send_byte(s[127-8*k -: 8]);
      if (gaps) tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_ready"},   {31'd0, rx_ready},   32'd0);
    check({tag, " im_we"},      {31'd0, im_we},      32'd0);
    check({tag, " im_addr"},    {20'd0, im_addr},    32'd0);
    check({tag, " im_wdata"},   im_wdata,            32'd0);
    check({tag, " core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    check({tag, " load_done"},  {31'd0, load_done},  32'd0);
    check({tag, " load_err"},   {31'd0, load_err},   32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("idle rx_ready", {31'd0, rx_ready}, 32'd1);
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_good_load(input string tag, input int base);
    check({tag, " write count"}, wa_q.size(), base + 2);
    check({tag, " addr0"}, {20'd0, wa_q[base]}, 32'd0);
    check({tag, " data0"}, wd_q[base], 32'h0000_0013);
    check({tag, " addr1"}, {20'd0, wa_q[base+1]}, 32'd1);
    check({tag, " data1"}, wd_q[base+1], 32'h0010_0093);
    check({tag, " load_done"}, {31'd0, load_done}, 32'd1);
    check({tag, " load_err"}, {31'd0, load_err}, 32'd0);
    check({tag, " core_rst_n"}, {31'd0, core_rst_n}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{"normal",   12, {GOOD_FRAME, 32'h0}, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0};
    vecs[1] = '{"bad_csum", 12, {BAD_FRAME, 32'h0},  2, 32'h0000_0013, 32'h0010_0093, 1'b0, 1'b1};
    vecs[2] = '{"garbage",  15, {24'h00FF13, GOOD_FRAME, 8'h0}, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0};
    vecs[3] = '{"zero_len", 4,  {32'hA500_0000, 96'h0}, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{"oversize", 3,  {24'hA501_10, 104'h0},  0, 32'h0, 32'h0, 1'b0, 1'b1};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      send_stream(vecs[v].stream, vecs[v].n, 1'b0);
      tick();
      check({vecs[v].name, " write count"}, wa_q.size(), vecs[v].exp_nw);
      if (vecs[v].exp_nw >= 1) begin
        check({vecs[v].name, " addr0"}, {20'd0, wa_q[0]}, 32'd0);
        check({vecs[v].name, " data0"}, wd_q[0], vecs[v].exp_w0);
      end
      if (vecs[v].exp_nw >= 2) begin
        check({vecs[v].name, " addr1"}, {20'd0, wa_q[1]}, 32'd1);
        check({vecs[v].name, " data1"}, wd_q[1], vecs[v].exp_w1);
      end
      check({vecs[v].name, " load_done"},  {31'd0, load_done},  {31'd0, vecs[v].exp_done});
      check({vecs[v].name, " load_err"},   {31'd0, load_err},   {31'd0, vecs[v].exp_err});
      check({vecs[v].name, " core_rst_n"}, {31'd0, core_rst_n}, {31'd0, vecs[v].exp_done});
      check({vecs[v].name, " rx_ready"},   {31'd0, rx_ready},   {31'd0, ~vecs[v].exp_done});
    end

    // Write pulse timing and done latency against the accepting edge.
    do_reset();
    send_stream({GOOD_FRAME, 32'h0}, 6, 1'b0);
    check("pulse pre im_we", {31'd0, im_we}, 32'd0);
    send_byte(8'h00);
    check("pulse im_we", {31'd0, im_we}, 32'd1);
    check("pulse im_addr", {20'd0, im_addr}, 32'd0);
    check("pulse im_wdata", im_wdata, 32'h0000_0013);
    tick();
    check("pulse im_we drop", {31'd0, im_we}, 32'd0);
    send_stream({GOOD_FRAME[39:0], 88'h0}, 4, 1'b0);
    check("pre csum load_done", {31'd0, load_done}, 32'd0);
    send_byte(8'h4A);
    check("latency load_done", {31'd0, load_done}, 32'd1);
    check("latency core_rst_n", {31'd0, core_rst_n}, 32'd1);

    // Oversize length is flagged as soon as LEN_HI is accepted.
    do_reset();
    send_stream({24'hA501_10, 104'h0}, 3, 1'b0);
    check("oversize immediate err", {31'd0, load_err}, 32'd1);

    // Bad frame followed by a correct frame recovers from ERR.
    do_reset();
    send_stream({BAD_FRAME, 32'h0}, 12, 1'b0);
    check("recover err set", {31'd0, load_err}, 32'd1);
    check("recover core held", {31'd0, core_rst_n}, 32'd0);
    send_stream({GOOD_FRAME, 32'h0}, 12, 1'b0);
    tick();
    check_good_load("recover", 2);

    // rx_valid toggling every cycle.
    do_reset();
    send_stream({GOOD_FRAME, 32'h0}, 12, 1'b1);
    check_good_load("stall", 0);

    // Reset after the fifth byte aborts the frame.
    do_reset();
    send_stream({GOOD_FRAME, 32'h0}, 5, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    #1;
    check("midreset rx_ready", {31'd0, rx_ready}, 32'd1);
    check("midreset no writes", wa_q.size(), 32'd0);
    send_stream({GOOD_FRAME, 32'h0}, 12, 1'b0);
    tick();
    check_good_load("midreset reload", 0);

    // Full-capacity image: N = 2**IM_AW words, word i holds value i.
    begin
      logic [7:0] sum;
      logic [31:0] w;
      int bad;
      do_reset();
      sum = 8'h00;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h10);
      for (int i = 0; i < (1 << IM_AW); i++) begin
        w = i;
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8]);
          sum = sum + w[8*b +: 8];
        end
      end
      send_byte(8'h00 - sum);
      tick();
      check("full write count", wa_q.size(), 32'd4096);
      bad = 0;
      for (int i = 0; i < wa_q.size(); i++) begin
        w = i;
        if (wa_q[i] !== w[IM_AW-1:0] || wd_q[i] !== w) bad++;
      end
      check("full word mismatches", bad, 32'd0);
      check("full last addr", {20'd0, wa_q[wa_q.size()-1]}, 32'd4095);
      check("full load_done", {31'd0, load_done}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rooth_inst_loader.md
Name: rooth_inst_loader

Overview:
- Synthesizable boot loader: hardware equivalent of the bench's load-then-release-reset sequence.
- Accepts a framed byte stream, typically from a UART receiver.
- Packs the payload into little-endian 32-bit words and writes them into instruction memory.
- Holds the rooth core in reset until a complete, checksum-valid image is written, then releases it.

Parameters:
- IM_AW, 12, instruction-memory word-address width; capacity = 2**IM_AW words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rx_valid  in  1  byte valid.
- rx_data  in  8  byte value.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- im_we  out  1  instruction-memory write strobe, one-cycle pulse.
- im_addr  out  IM_AW  word address.
- im_wdata  out  32  write data.
- core_rst_n  out  1  reset to core; 0 = held in reset.
- load_done  out  1  image loaded and verified (level).
- load_err  out  1  frame error (level).

Behaviour:
- Reset: one clock domain; reset is synchronous, active-low, on rst_n sampled at posedge clk.
  - During reset: all outputs 0 (core_rst_n = 0, rx_ready = 0, im_we = 0, im_addr = 0, im_wdata = 0, load_done = 0, load_err = 0).
  - After reset: state = IDLE.
  - Reset mid-frame aborts the load. The partial image stays in memory, but the core remains held in reset.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes (LSB first per word), then CSUM.
  - The frame is valid iff (sum of payload bytes + CSUM) mod 256 == 0.
- Acceptance rate: at most one byte per cycle. rx_ready = 1 in IDLE, LEN0, LEN1, DATA, CSUM and ERR; 0 in DONE and during reset.
- State machine (transitions only on an accepted byte):
  - IDLE: SYNC_BYTE -> LEN0; any other byte is discarded.
  - LEN0: latch LEN_LO -> LEN1.
  - LEN1: latch LEN_HI. If N == 0 -> CSUM. If N > 2**IM_AW -> ERR. Otherwise -> DATA, with word counter = 0 and byte index = 0.
  - DATA:
    - Each byte is shifted into byte lane [index] of the packing register and added to the 8-bit running sum.
    - On the 4th byte: the next cycle shows im_we = 1, im_addr = word counter, im_wdata = the packed word (registered, latency 1 cycle from the accepting edge). The word counter then increments.
    - After word N-1 is written -> CSUM.
  - CSUM: on match -> DONE, else -> ERR.
  - DONE: load_done = 1 and core_rst_n = 1, both registered and both asserted in the cycle after the CSUM byte is accepted. Sticky until rst_n.
  - ERR: load_err = 1 and core_rst_n = 0. Receiving SYNC_BYTE clears load_err and -> LEN0; other bytes are discarded.
- Data-byte handling: a payload byte equal to SYNC_BYTE is treated as data (no resync inside a frame).
- Running sum: 8 bits, wraps modulo 256. The length bytes are not included in the sum.
- Gaps: rx_valid low for any number of cycles leaves all state frozen; there is no timeout.
- Word counter width: IM_AW+1 bits, so N == 2**IM_AW is legal. The last address is 2**IM_AW - 1; no wrap.

Decomposition:
- Add to rooth_defines.v:
  - LDR_SYNC (8'hA5);
  - state encodings LDR_IDLE, LDR_LEN0, LDR_LEN1, LDR_DATA, LDR_CSUM, LDR_DONE, LDR_ERR (3 bits);
  - CPU_WIDTH reused for the 32-bit word width.
- One sub-module: rooth_byte_packer.
  - Contents: byte lane index, 32-bit shift/assemble register, 8-bit running sum.
  - Outputs: word_valid pulse and word.
  - Controls: cleared by the FSM on the transition into DATA.

Test Plan:
- Normal 2-word load: bytes A5 02 00 13 00 00 00 93 00 10 00 4A.
  - Writes addr0 = 0x00000013 and addr1 = 0x00100093, one im_we pulse each.
  - load_done = 1 and core_rst_n = 1 one cycle after 4A is accepted.
- Bad checksum: same frame with CSUM = 4B.
  - Both words are written, load_err = 1, core_rst_n stays 0.
  - A following correct frame yields load_done = 1 and load_err = 0.
- Garbage before sync: 00 FF 13 then the normal frame.
  - The first three bytes produce no writes; result is identical to the normal load.
- Zero length: A5 00 00 00.
  - No im_we; load_done = 1.
- Oversize: A5 01 10 with IM_AW = 12 (N = 4097).
  - load_err = 1 immediately after LEN_HI is accepted; no writes.
- Stalls and reset:
  - rx_valid toggled 1/0 every cycle across the normal frame gives identical writes.
  - rst_n pulsed low after the 5th byte: all outputs 0 and state IDLE; a re-sent frame then loads correctly.
